// File: rtl/blade_reset_pkg.sv
// Shared definitions for the blade reset sequencer.
//   seq_state_e : sequencer FSM state, also exported on SEQ_STATE for debug
//   max()       : elaboration-time helper used to size the step counter
package blade_reset_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } seq_state_e;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/blade_reset_sync.sv
// Reset release synchroniser: a STAGES-deep shift of constant 1, cleared
// asynchronously. Assertion is immediate, release is synchronous to clk.
//   clk    : domain clock
//   rst_n  : asynchronous active-low reset
//   rst_ok : high once STAGES rising edges have elapsed since rst_n rose
module blade_reset_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_ok
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_ok = sync_q[STAGES-1];

endmodule

// File: rtl/blade_reset_seq.sv
// Power-on / soft reset sequencer with heartbeat LED.
// Holds all lanes in reset for HOLD_CYCLES after the synchronised release
// (or a soft request), then releases lanes in index order every STAGGER
// cycles. ALL_READY marks the RUN state.
//   CLK                : sole clock
//   MIB_MASTER_RESET_N : asynchronous active-low master reset
//   SW_RESET_REQ       : synchronous soft re-sequence request (level)
//   CH_RESET           : per-lane active-high resets
//   ALL_READY          : high in RUN
//   FPGA_LED           : 1 while sequencing, heartbeat bit in RUN
//   SEQ_STATE          : FSM state (HOLD=0, RELEASE=1, RUN=2)
module blade_reset_seq
    import blade_reset_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LED_DIV_BIT = 24
) (
    input  logic              CLK,
    input  logic              MIB_MASTER_RESET_N,
    input  logic              SW_RESET_REQ,
    output logic [NUM_CH-1:0] CH_RESET,
    output logic              ALL_READY,
    output logic              FPGA_LED,
    output logic [1:0]        SEQ_STATE
);

    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("blade_reset_seq: NUM_CH must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("blade_reset_seq: HOLD_CYCLES must be >= 1");
    end
    if (STAGGER < 1) begin : g_bad_stagger
        $error("blade_reset_seq: STAGGER must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("blade_reset_seq: SYNC_STAGES must be >= 2");
    end
    if (LED_DIV_BIT < 0) begin : g_bad_led
        $error("blade_reset_seq: LED_DIV_BIT must be >= 0");
    end

    localparam int CNT_W = $clog2(max(HOLD_CYCLES, STAGGER)) + 1;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);

    logic rst_ok;

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NUM_CH-1:0] ch_q, ch_d;
    logic              ready_q, ready_d;
    logic [LED_DIV_BIT:0] led_ctr;
    logic              led_q;

    blade_reset_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (CLK),
        .rst_n (MIB_MASTER_RESET_N),
        .rst_ok(rst_ok)
    );

    always_ff @(posedge CLK or negedge MIB_MASTER_RESET_N) begin
        if (!MIB_MASTER_RESET_N) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            ch_q    <= '1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ch_q    <= ch_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ch_d    = ch_q;
        ready_d = ready_q;

        if (!rst_ok) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
        end else if (SW_RESET_REQ) begin
            // Soft request outranks any release scheduled on this edge.
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            ch_d    = '1;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        ch_d[0] = 1'b0;
                        cnt_d   = '0;
                        idx_d   = '0;
                        if (NUM_CH == 1) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == STAG_LAST) begin
                        for (int unsigned k = 0; k < NUM_CH; k++) begin
                            if (k == 32'(idx_q) + 32'd1) begin
                                ch_d[k] = 1'b0;
                            end
                        end
                        idx_d = idx_q + 1'b1;
                        cnt_d = '0;
                        if (int'(idx_q) + 1 == NUM_CH - 1) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

    // Heartbeat counter runs from master reset only; soft requests leave it alone.
    always_ff @(posedge CLK or negedge MIB_MASTER_RESET_N) begin
        if (!MIB_MASTER_RESET_N) begin
            led_ctr <= '0;
            led_q   <= 1'b0;
        end else begin
            led_ctr <= led_ctr + 1'b1;
            led_q   <= (state_q == ST_RUN) ? led_ctr[LED_DIV_BIT] : 1'b1;
        end
    end

    assign CH_RESET  = ch_q;
    assign ALL_READY = ready_q;
    assign FPGA_LED  = led_q;
    assign SEQ_STATE = state_q;

endmodule

// File: tb/tb_blade_reset_seq.sv
// Self-checking bench for blade_reset_seq. Two instances share clock, master
// reset and soft request: a four-lane build and a single-lane build. The
// reference model works in absolute edge numbers: each lane's release edge is
// derived from the most recent sequence origin (power-on or soft request).
module tb_blade_reset_seq;

    localparam int S     = 2;
    localparam int N_A   = 4;
    localparam int H_A   = 16;
    localparam int ST_A  = 8;
    localparam int LED_A = 3;
    localparam int N_B   = 1;
    localparam int H_B   = 3;
    localparam int ST_B  = 8;
    localparam int LED_B = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic sw;

    logic [N_A-1:0] ch_a;
    logic           rdy_a, led_a;
    logic [1:0]     st_a;
    logic [N_B-1:0] ch_b;
    logic           rdy_b, led_b;
    logic [1:0]     st_b;

    always #5 clk = ~clk;

    blade_reset_seq #(
        .NUM_CH(N_A), .HOLD_CYCLES(H_A), .STAGGER(ST_A),
        .SYNC_STAGES(S), .LED_DIV_BIT(LED_A)
    ) u_dut_a (
        .CLK(clk), .MIB_MASTER_RESET_N(rst_n), .SW_RESET_REQ(sw),
        .CH_RESET(ch_a), .ALL_READY(rdy_a), .FPGA_LED(led_a), .SEQ_STATE(st_a)
    );

    blade_reset_seq #(
        .NUM_CH(N_B), .HOLD_CYCLES(H_B), .STAGGER(ST_B),
        .SYNC_STAGES(S), .LED_DIV_BIT(LED_B)
    ) u_dut_b (
        .CLK(clk), .MIB_MASTER_RESET_N(rst_n), .SW_RESET_REQ(sw),
        .CH_RESET(ch_b), .ALL_READY(rdy_b), .FPGA_LED(led_b), .SEQ_STATE(st_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: edges since master release and lane-0 release edge.
    int n;
    int base_a, base_b;
    int prev_a, prev_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    function automatic int m_state(input int e, input int base, input int nch, input int st);
        if (e < base) return 0;
        if (e >= base + (nch - 1) * st) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] m_lanes(input int e, input int base, input int nch, input int st);
        logic [31:0] v = '0;
        for (int k = 0; k < nch; k++) v[k] = (e < base + k * st);
        return v;
    endfunction

    function automatic logic [31:0] m_led(input int e, input int prev_state, input int bitpos);
        if (e == 0) return 32'd0;
        if (prev_state == 2) return 32'(((e - 1) >> bitpos) & 1);
        return 32'd1;
    endfunction

    task automatic check_outputs();
        int sa, sb;
        sa = m_state(n, base_a, N_A, ST_A);
        sb = m_state(n, base_b, N_B, ST_B);
        chk("a_lanes", 32'(ch_a), m_lanes(n, base_a, N_A, ST_A));
        chk("a_ready", 32'(rdy_a), 32'(sa == 2));
        chk("a_state", 32'(st_a), 32'(sa));
        chk("a_led",   32'(led_a), m_led(n, prev_a, LED_A));
        chk("b_lanes", 32'(ch_b), m_lanes(n, base_b, N_B, ST_B));
        chk("b_ready", 32'(rdy_b), 32'(sb == 2));
        chk("b_state", 32'(st_b), 32'(sb));
        chk("b_led",   32'(led_b), m_led(n, prev_b, LED_B));
    endtask

    // Called at a falling edge; pulses reset low between rising edges.
    task automatic do_reset();
        sw    = 1'b0;
        rst_n = 1'b0;
        #2;
        n      = 0;
        base_a = S + H_A;
        base_b = S + H_B;
        prev_a = 0;
        prev_b = 0;
        check_outputs();
        #1;
        rst_n = 1'b1;
    endtask

    // One rising edge with the given soft request level, checked at the falling edge.
    task automatic step(input logic req);
        sw = req;
        @(posedge clk);
        prev_a = m_state(n, base_a, N_A, ST_A);
        prev_b = m_state(n, base_b, N_B, ST_B);
        n++;
        if (req) begin
            base_a = (n + H_A > S + H_A) ? n + H_A : S + H_A;
            base_b = (n + H_B > S + H_B) ? n + H_B : S + H_B;
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        int hold;
        rst_n = 1'b0;
        sw    = 1'b0;
        n     = 0;
        hold  = 0;
        @(negedge clk);

        // Power-on sequence, then a one-cycle soft request at edge 100 in RUN.
        do_reset();
        for (int e = 1; e <= 150; e++) step(e == 100);

        // Master reset mid-RELEASE, then a request on lane 2's release edge.
        do_reset();
        for (int e = 1; e <= 30; e++) step(1'b0);
        do_reset();
        for (int e = 1; e <= 60; e++) step(e == 34);

        // Random soft requests (single and held) with occasional master resets.
        for (int i = 0; i < 800; i++) begin
            logic req;
            if ($urandom_range(0, 299) == 0) do_reset();
            if (hold > 0) begin
                req = 1'b1;
                hold--;
            end else if ($urandom_range(0, 59) == 0) begin
                req  = 1'b1;
                hold = $urandom_range(1, 5);
            end else begin
                req = ($urandom_range(0, 39) == 0);
            end
            step(req);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
